mc_program_sequencer: RTL and testbench

//  Program sequencer for the MC14500B ICU. Owns the program counter and fetches
//  {opcode, operand address} words from a synchronous program ROM. Issues each

---
 rtl/mc_program_sequencer_if.sv | 42 ++++
 rtl/mc_program_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_mc_program_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_program_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_program_sequencer_if
// Purpose  : Bundles the program ROM bus, the ICU req/ack handshake, the ICU
//            decode outputs and the run/status lines of the MC14500B program
//            sequencer.
// Ports    : master - the sequencer: drives prog_addr, icu_instr, io_addr,
//                     icu_req, busy, halted, fault; receives run, prog_data,
//                     icu_ack, icu_jmp, icu_rtn, icu_flag_o, icu_flag_f.
//            slave  - the ROM/ICU/host environment, the mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface mc_program_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int OP_W   = 4
);
    logic                     run;
    logic [ADDR_W-1:0]        prog_addr;
    logic [OP_W+ADDR_W-1:0]   prog_data;
    logic [OP_W-1:0]          icu_instr;
    logic [ADDR_W-1:0]        io_addr;
    logic                     icu_req;
    logic                     icu_ack;
    logic                     icu_jmp;
    logic                     icu_rtn;
    logic                     icu_flag_o;
    logic                     icu_flag_f;
    logic                     busy;
    logic                     halted;
    logic                     fault;

    modport master (
        input  run, prog_data, icu_ack, icu_jmp, icu_rtn, icu_flag_o, icu_flag_f,
        output prog_addr, icu_instr, io_addr, icu_req, busy, halted, fault
    );

    modport slave (
        output run, prog_data, icu_ack, icu_jmp, icu_rtn, icu_flag_o, icu_flag_f,
        input  prog_addr, icu_instr, io_addr, icu_req, busy, halted, fault
    );
endinterface
`default_nettype wire

// File: rtl/mc_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mc_program_sequencer
// Purpose  : Program sequencer for the MC14500B ICU. Owns the program counter,
//            fetches {opcode, operand} words from a synchronous ROM, issues
//            each opcode over a four-phase req/ack handshake and then acts on
//            the ICU's JMP/RTN/NOPO/NOPF outputs (jump, call, return, halt).
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - mc_program_sequencer_if.master (ROM, ICU and status lines)
// Revision : 1.0 - initial release
// ============================================================================
module mc_program_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int OP_W        = 4,
    parameter int STACK_DEPTH = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mc_program_sequencer_if.master  bus
);

    localparam int TW  = $clog2(ACK_TIMEOUT + 1);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [TW-1:0]  c_TIMEOUT = TW'(ACK_TIMEOUT);
    localparam logic [SPW-1:0] c_FULL    = SPW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_REQ   = 3'd3,
        S_FLAGS = 3'd4,
        S_REL   = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [SPW-1:0]      r_sp;
    logic                r_call_arm;
    logic [OP_W-1:0]     r_instr;
    logic [ADDR_W-1:0]   r_io_addr;
    logic [TW-1:0]       r_timer;
    logic                r_fault;
    logic                r_ack_s1, r_ack_s2;
    logic                r_jmp, r_rtn, r_flag_o, r_flag_f;
    logic [ADDR_W-1:0]   r_stack [STACK_DEPTH];

    logic                w_req, w_latch, w_sample, w_timer_clr, w_timer_inc;
    logic                w_set_fault, w_commit, w_advance;
    logic [IW-1:0]       w_push_idx, w_pop_idx;

    assign w_push_idx = r_sp[IW-1:0];
    assign w_pop_idx  = IW'(r_sp - SPW'(1));
    // The PC only moves when the handshake completes without halting: a NOPF
    // or a stack fault leaves it pointing at the offending instruction.
    assign w_advance  = w_commit && (w_next != S_HALT);

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // ---------------- FSM next-state / control ----------------
    always_comb begin
        w_next      = r_state;
        w_req       = 1'b0;
        w_latch     = 1'b0;
        w_sample    = 1'b0;
        w_timer_clr = 1'b0;
        w_timer_inc = 1'b0;
        w_set_fault = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.run) w_next = S_FETCH;
            S_FETCH: w_next = S_LATCH;
            S_LATCH: begin
                w_latch     = 1'b1;
                w_timer_clr = 1'b1;
                w_next      = S_REQ;
            end
            S_REQ: begin
                w_req = 1'b1;
                if (r_ack_s2) begin
                    w_next = S_FLAGS;
                end else if (r_timer == c_TIMEOUT) begin
                    w_set_fault = 1'b1;
                    w_next      = S_HALT;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            S_FLAGS: begin
                // Ack has been seen through the synchroniser, so the ICU's
                // decode outputs have long settled.
                w_req       = 1'b1;
                w_sample    = 1'b1;
                w_timer_clr = 1'b1;
                w_next      = S_REL;
            end
            S_REL: begin
                if (!r_ack_s2) begin
                    w_commit = 1'b1;
                    if (r_flag_f) begin
                        w_next = S_HALT;
                    end else if (r_jmp && r_call_arm && (r_sp == c_FULL)) begin
                        w_set_fault = 1'b1;
                        w_next      = S_HALT;
                    end else if (!r_jmp && r_rtn && (r_sp == '0)) begin
                        w_set_fault = 1'b1;
                        w_next      = S_HALT;
                    end else begin
                        w_next = bus.run ? S_FETCH : S_IDLE;
                    end
                end else if (r_timer == c_TIMEOUT) begin
                    w_set_fault = 1'b1;
                    w_next      = S_HALT;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= '0;
            r_sp       <= '0;
            r_call_arm <= 1'b0;
            r_instr    <= '0;
            r_io_addr  <= '0;
            r_timer    <= '0;
            r_fault    <= 1'b0;
            r_ack_s1   <= 1'b0;
            r_ack_s2   <= 1'b0;
            r_jmp      <= 1'b0;
            r_rtn      <= 1'b0;
            r_flag_o   <= 1'b0;
            r_flag_f   <= 1'b0;
        end else begin
            r_ack_s1 <= bus.icu_ack;
            r_ack_s2 <= r_ack_s1;

            if (w_timer_clr)      r_timer <= '0;
            else if (w_timer_inc) r_timer <= r_timer + TW'(1);

            if (w_set_fault) r_fault <= 1'b1;

            if (w_latch) begin
                r_instr   <= bus.prog_data[OP_W+ADDR_W-1 -: OP_W];
                r_io_addr <= bus.prog_data[ADDR_W-1:0];
            end

            if (w_sample) begin
                r_jmp    <= bus.icu_jmp;
                r_rtn    <= bus.icu_rtn;
                r_flag_o <= bus.icu_flag_o;
                r_flag_f <= bus.icu_flag_f;
            end

            if (w_advance) begin
                // NOPO arms a call for exactly the next executed instruction.
                r_call_arm <= r_flag_o;
                if (r_jmp) begin
                    if (r_call_arm) r_sp <= r_sp + SPW'(1);
                    r_pc <= r_io_addr;
                end else if (r_rtn) begin
                    r_pc <= r_stack[w_pop_idx];
                    r_sp <= r_sp - SPW'(1);
                end else begin
                    r_pc <= r_pc + ADDR_W'(1);
                end
            end
        end
    end

    // Return-address stack contents need no reset; sp qualifies them.
    always_ff @(posedge clk) begin
        if (w_advance && r_jmp && r_call_arm)
            r_stack[w_push_idx] <= r_pc + ADDR_W'(1);
    end

    // ---------------- Outputs ----------------
    assign bus.prog_addr = r_pc;
    assign bus.icu_instr = r_instr;
    assign bus.io_addr   = r_io_addr;
    assign bus.icu_req   = w_req;
    assign bus.busy      = (r_state != S_IDLE) && (r_state != S_HALT);
    assign bus.halted    = (r_state == S_HALT);
    assign bus.fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mc_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_program_sequencer
// Purpose  : Self-checking bench for mc_program_sequencer. A table of
//            {pc, opcode, operand} records both fills the ROM and forms the
//            expected instruction trace, which is queued and compared each
//            time the sequencer raises icu_req. Hand-written sequences cover
//            ack timeout, PC wrap and asynchronous reset mid-handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_program_sequencer;

    localparam int ADDR_W = 8;
    localparam int OP_W   = 4;

    localparam logic [3:0] c_NOPO = 4'h0, c_LD = 4'h1, c_STO = 4'h8,
                           c_JMP = 4'hC, c_RTN = 4'hD, c_NOPF = 4'hF;

    typedef struct packed {
        logic [7:0] pc;
        logic [3:0] op;
        logic [7:0] opnd;
    } exp_t;

    typedef struct {
        int   scen;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold_ack = 1'b0;
    logic r_ack_q;
    logic [11:0] rom [0:255];
    logic [11:0] rom_q;
    logic prev_req = 1'b0;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q [$];
    vec_t tbl  [$];

    mc_program_sequencer_if #(.ADDR_W(ADDR_W), .OP_W(OP_W)) bus ();

    mc_program_sequencer #(
        .ADDR_W(ADDR_W), .OP_W(OP_W), .STACK_DEPTH(4), .ACK_TIMEOUT(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: data one clock after the address.
    always @(posedge clk) rom_q <= rom[bus.prog_addr];
    assign bus.prog_data = rom_q;

    // ICU model: ack follows req one clock later; decode outputs valid while req.
    always @(posedge clk or posedge rst) begin
        if (rst) r_ack_q <= 1'b0;
        else     r_ack_q <= hold_ack ? 1'b0 : bus.icu_req;
    end
    assign bus.icu_ack    = r_ack_q;
    assign bus.icu_jmp    = bus.icu_req && (bus.icu_instr == c_JMP);
    assign bus.icu_rtn    = bus.icu_req && (bus.icu_instr == c_RTN);
    assign bus.icu_flag_o = bus.icu_req && (bus.icu_instr == c_NOPO);
    assign bus.icu_flag_f = bus.icu_req && (bus.icu_instr == c_NOPF);

    function automatic void add(int s, logic [7:0] pc, logic [3:0] op, logic [7:0] d);
        vec_t v;
        v.scen = s;
        v.e    = {pc, op, d};
        tbl.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock step, sampled on the falling edge; scoreboard pops on req rise.
    task automatic tick();
        exp_t got, e;
        @(negedge clk);
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (bus.icu_req && !prev_req) begin
                got = {bus.prog_addr, bus.icu_instr, bus.io_addr};
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got pc/op/opnd %h none expected", got);
                end else begin
                    e = sb_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL sb_trace: got pc/op/opnd %h expected %h", got, e);
                    end
                end
            end
            prev_req = bus.icu_req;
        end
    endtask

    task automatic do_reset();
        bus.run  = 1'b0;
        hold_ack = 1'b0;
        rst      = 1'b1;
        sb_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load_scen(int s);
        for (int i = 0; i < 256; i++) rom[i] = {c_NOPF, 8'h00};
        foreach (tbl[i]) begin
            if (tbl[i].scen == s) begin
                rom[tbl[i].e.pc] = {tbl[i].e.op, tbl[i].e.opnd};
                sb_q.push_back(tbl[i].e);
            end
        end
    endtask

    task automatic wait_halted(string name, int bound);
        int n = 0;
        while (!bus.halted && n < bound) begin
            tick();
            n++;
        end
        check(name, {31'd0, bus.halted}, 32'd1);
    endtask

    task automatic wait_sb_empty(string name, int bound);
        int n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check(name, sb_q.size(), 32'd0);
    endtask

    initial begin
        int n;
        bus.run = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = {c_NOPF, 8'h00};

        // ---- stimulus/expectation table ----
        // 1: straight-line program ending in NOPF
        add(1, 8'h00, c_LD,  8'h03);
        add(1, 8'h01, c_STO, 8'h05);
        add(1, 8'h02, c_NOPF, 8'h00);
        // 2: jumps, NOPO-armed call, return, then an unarmed JMP and a RTN underflow
        add(2, 8'h00, c_JMP, 8'h10);
        add(2, 8'h10, c_JMP, 8'h40);
        add(2, 8'h40, c_JMP, 8'h05);
        add(2, 8'h05, c_NOPO, 8'h00);
        add(2, 8'h06, c_JMP, 8'h20);
        add(2, 8'h20, c_RTN, 8'h00);
        add(2, 8'h07, c_JMP, 8'h30);
        add(2, 8'h30, c_RTN, 8'h00);
        // 3: five nested calls into a 4-deep stack
        for (int k = 0; k < 5; k++) begin
            add(3, 8'(k * 16),     c_NOPO, 8'h00);
            add(3, 8'(k * 16 + 1), c_JMP,  8'((k + 1) * 16));
        end
        // 5: PC wrap through 0xFF
        add(5, 8'h00, c_JMP, 8'hFE);
        add(5, 8'hFE, c_LD,  8'h02);
        add(5, 8'hFF, c_LD,  8'h01);
        add(5, 8'h00, c_JMP, 8'hFE);
        add(5, 8'hFE, c_LD,  8'h02);

        // ---- reset state, idle with run=0 ----
        do_reset();
        repeat (4) tick();
        check("rst_busy",      {31'd0, bus.busy},    32'd0);
        check("rst_halted",    {31'd0, bus.halted},  32'd0);
        check("rst_fault",     {31'd0, bus.fault},   32'd0);
        check("rst_req",       {31'd0, bus.icu_req}, 32'd0);
        check("rst_instr",     {28'd0, bus.icu_instr}, 32'd0);
        check("rst_io_addr",   {24'd0, bus.io_addr},   32'd0);
        check("rst_prog_addr", {24'd0, bus.prog_addr}, 32'd0);

        // ---- scenario 1 ----
        load_scen(1);
        bus.run = 1'b1;
        wait_halted("s1_halted", 200);
        check("s1_trace_done", sb_q.size(), 32'd0);
        check("s1_pc",    {24'd0, bus.prog_addr}, 32'h02);
        check("s1_fault", {31'd0, bus.fault},     32'd0);
        check("s1_busy",  {31'd0, bus.busy},      32'd0);

        // ---- scenario 2 ----
        do_reset();
        load_scen(2);
        bus.run = 1'b1;
        wait_halted("s2_halted", 400);
        check("s2_trace_done", sb_q.size(), 32'd0);
        check("s2_fault", {31'd0, bus.fault},     32'd1);
        check("s2_pc",    {24'd0, bus.prog_addr}, 32'h30);
        repeat (3) tick();
        check("s2_run_ignored_in_halt", {31'd0, bus.halted}, 32'd1);

        // ---- scenario 3: stack overflow ----
        do_reset();
        load_scen(3);
        bus.run = 1'b1;
        wait_halted("s3_halted", 500);
        check("s3_trace_done", sb_q.size(), 32'd0);
        check("s3_fault", {31'd0, bus.fault},     32'd1);
        check("s3_pc",    {24'd0, bus.prog_addr}, 32'h41);

        // ---- scenario 4: ack never arrives ----
        do_reset();
        load_scen(4);
        rom[0] = {c_LD, 8'h01};
        sb_q.push_back({8'h00, c_LD, 8'h01});
        hold_ack = 1'b1;
        bus.run  = 1'b1;
        n = 0;
        while (!bus.icu_req && n < 20) begin tick(); n++; end
        check("s4_req_seen", {31'd0, bus.icu_req}, 32'd1);
        n = 0;
        while (bus.icu_req && !bus.halted && n < 40) begin tick(); n++; end
        check("s4_timeout_len", {31'd0, (n >= 15 && n <= 17)}, 32'd1);
        check("s4_fault",  {31'd0, bus.fault},   32'd1);
        check("s4_halted", {31'd0, bus.halted},  32'd1);
        check("s4_req",    {31'd0, bus.icu_req}, 32'd0);
        hold_ack = 1'b0;

        // ---- scenario 5: wrap, then async reset during REQ ----
        do_reset();
        load_scen(5);
        bus.run = 1'b1;
        wait_sb_empty("s5_wrap_trace", 300);
        check("s5_req_before_rst", {31'd0, bus.icu_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("s5_req_async_drop", {31'd0, bus.icu_req},   32'd0);
        check("s5_busy_after_rst", {31'd0, bus.busy},      32'd0);
        check("s5_pc_after_rst",   {24'd0, bus.prog_addr}, 32'd0);
        tick();
        sb_q.push_back({8'h00, c_JMP, 8'hFE});
        rst = 1'b0;
        wait_sb_empty("s5_restart_addr0", 100);
        bus.run = 1'b0;
        n = 0;
        while (bus.busy && n < 60) begin tick(); n++; end
        check("s5_idle_on_run0", {31'd0, bus.busy},  32'd0);
        check("s5_no_fault",     {31'd0, bus.fault}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
